// File: rtl/rl_pkg.sv
// Shared definitions for the grid-world Q-learning blocks: grid geometry,
// action encodings, FSM state type and the Q-table address mapping.
package rl_pkg;

    localparam int N_STATES   = 25;
    localparam int GRID_W     = 5;
    localparam int N_ACTIONS  = 4;
    localparam int GOAL_STATE = 25;
    localparam int Q_W        = 16;
    localparam int ADDR_W     = 7;
    localparam int STATE_W    = 6;

    // Action encodings, shared with the state-transition block.
    typedef enum logic [1:0] {
        ACT_RIGHT = 2'd0,
        ACT_UP    = 2'd1,
        ACT_LEFT  = 2'd2,
        ACT_DOWN  = 2'd3
    } action_e;

    // Q update sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DRAIN = 3'd2,
        ST_CALC  = 3'd3,
        ST_WRITE = 3'd4
    } qu_state_e;

    // Q-table entry for (state, action): states are 1-based, four actions each.
    function automatic logic [ADDR_W-1:0] q_addr(input logic [STATE_W-1:0] s,
                                                 input logic [1:0]         a);
        logic [ADDR_W-1:0] base;
        base = {1'b0, s} - 7'd1;
        return (base << 2) + {5'd0, a};
    endfunction

    // True when a state number lies on the grid (1..N_STATES).
    function automatic logic state_valid(input logic [STATE_W-1:0] s);
        return (s >= 6'd1) && (s <= 6'(N_STATES));
    endfunction

endpackage

// File: rtl/q_max4.sv
// Combinational signed maximum of four Q values, built as a two-level
// compare tree. On ties either operand is chosen; the value is identical.
module q_max4 #(
    parameter int W = 16
) (
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [W-1:0] in3,
    output logic [W-1:0] max_q
);

    logic signed [W-1:0] leaf [4];
    logic signed [W-1:0] pair [2];

    assign leaf[0] = in0;
    assign leaf[1] = in1;
    assign leaf[2] = in2;
    assign leaf[3] = in3;

    // First level: winner of each adjacent pair.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_pair
            assign pair[gi] = (leaf[2*gi] >= leaf[2*gi+1]) ? leaf[2*gi] : leaf[2*gi+1];
        end
    endgenerate

    // Second level: overall winner.
    assign max_q = (pair[0] >= pair[1]) ? pair[0] : pair[1];

endmodule

// File: rtl/q_update_unit.sv
// One-step Q-learning update: fetches Q(s,a) and Q(s',0..3) from an external
// table with one-cycle read latency, computes
//   Q(s,a) += alpha * (r + gamma*max Q(s',.) - Q(s,a))
// and writes the saturated result back. Invalid requests finish immediately
// with err set and no write.
module q_update_unit
    import rl_pkg::*;
#(
    parameter int         Q_W         = rl_pkg::Q_W,
    parameter int         ALPHA_SHIFT = 2,
    parameter logic [7:0] GAMMA       = 8'd230
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [5:0]     current_state,
    input  logic [3:0]     at,
    input  logic [5:0]     next_state,
    input  logic [Q_W-1:0] reward,
    output logic [6:0]     q_rd_addr,
    input  logic [Q_W-1:0] q_rd_data,
    output logic           q_wr_en,
    output logic [6:0]     q_wr_addr,
    output logic [Q_W-1:0] q_wr_data,
    output logic           busy,
    output logic           done,
    output logic           err
);

    // Arithmetic width: two guard bits above the Q format.
    localparam int CW = Q_W + 2;
    localparam logic signed [CW-1:0] Q_MAX = {3'b000, {(Q_W-1){1'b1}}};
    localparam logic signed [CW-1:0] Q_MIN = {3'b111, {(Q_W-1){1'b0}}};

    qu_state_e      state_q, state_d;
    logic [2:0]     idx_q, idx_d;
    logic [5:0]     s_q, s_d;
    logic [1:0]     a_q, a_d;
    logic [5:0]     sn_q, sn_d;
    logic [Q_W-1:0] r_q, r_d;
    logic [Q_W-1:0] q_sa_q, q_sa_d;
    logic [Q_W-1:0] qn_q [4];
    logic [Q_W-1:0] qn_d [4];
    logic [6:0]     rd_addr_q, rd_addr_d;
    logic           wr_en_q, wr_en_d;
    logic [6:0]     wr_addr_q, wr_addr_d;
    logic [Q_W-1:0] wr_data_q, wr_data_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    logic                 inputs_ok;
    logic [Q_W-1:0]       max_q;
    logic signed [Q_W+8:0] disc_prod;
    logic signed [CW-1:0] disc;
    logic signed [CW-1:0] target;
    logic signed [CW-1:0] td;
    logic signed [CW-1:0] sa_ext;
    logic signed [CW-1:0] q_new_wide;
    logic [Q_W-1:0]       q_new_sat;
    logic                 unused_frac;

    q_max4 #(.W(Q_W)) u_max4 (
        .in0   (qn_q[0]),
        .in1   (qn_q[1]),
        .in2   (qn_q[2]),
        .in3   (qn_q[3]),
        .max_q (max_q)
    );

    assign inputs_ok = state_valid(current_state) && state_valid(next_state) && (at < 4'd4);

    // TD update datapath, evaluated on the captured operands during CALC.
    always_comb begin
        disc_prod  = $signed({{Q_W{1'b0}}, GAMMA}) * $signed({{9{max_q[Q_W-1]}}, max_q});
        // Terminal transition: no future value is bootstrapped.
        if (sn_q == 6'(GOAL_STATE)) begin
            disc = '0;
        end else begin
            disc = {disc_prod[Q_W+8], disc_prod[Q_W+8:8]};
        end
        sa_ext     = {{2{q_sa_q[Q_W-1]}}, q_sa_q};
        target     = $signed({{2{r_q[Q_W-1]}}, r_q}) + disc;
        td         = target - sa_ext;
        q_new_wide = sa_ext + (td >>> ALPHA_SHIFT);
        if (q_new_wide > Q_MAX) begin
            q_new_sat = Q_MAX[Q_W-1:0];
        end else if (q_new_wide < Q_MIN) begin
            q_new_sat = Q_MIN[Q_W-1:0];
        end else begin
            q_new_sat = q_new_wide[Q_W-1:0];
        end
    end

    // Fractional bits of gamma*maxQ are dropped by the Q0.8 scaling.
    assign unused_frac = ^disc_prod[7:0];

    // Sequencer next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        s_d       = s_q;
        a_d       = a_q;
        sn_d      = sn_q;
        r_d       = r_q;
        q_sa_d    = q_sa_q;
        qn_d      = qn_q;
        rd_addr_d = 7'd0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    s_d   = current_state;
                    a_d   = at[1:0];
                    sn_d  = next_state;
                    r_d   = reward;
                    idx_d = 3'd0;
                    if (inputs_ok) begin
                        state_d   = ST_FETCH;
                        rd_addr_d = q_addr(current_state, at[1:0]);
                    end else begin
                        // Rejected request: report immediately, never touch the table.
                        state_d   = ST_WRITE;
                        wr_addr_d = 7'd0;
                        wr_data_d = '0;
                        done_d    = 1'b1;
                        err_d     = 1'b1;
                    end
                end
            end

            ST_FETCH: begin
                // Data returned now belongs to the address issued at idx-1.
                case (idx_q)
                    3'd1:    q_sa_d  = q_rd_data;
                    3'd2:    qn_d[0] = q_rd_data;
                    3'd3:    qn_d[1] = q_rd_data;
                    3'd4:    qn_d[2] = q_rd_data;
                    default: ;
                endcase
                if (idx_q == 3'd4) begin
                    state_d = ST_DRAIN;
                end else begin
                    idx_d     = idx_q + 3'd1;
                    rd_addr_d = q_addr(sn_q, idx_q[1:0]);
                end
            end

            ST_DRAIN: begin
                qn_d[3] = q_rd_data;
                state_d = ST_CALC;
            end

            ST_CALC: begin
                state_d   = ST_WRITE;
                wr_en_d   = 1'b1;
                wr_addr_d = q_addr(s_q, a_q);
                wr_data_d = q_new_sat;
                done_d    = 1'b1;
            end

            ST_WRITE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= 3'd0;
            s_q       <= 6'd0;
            a_q       <= 2'd0;
            sn_q      <= 6'd0;
            r_q       <= '0;
            q_sa_q    <= '0;
            for (int i = 0; i < 4; i++) begin
                qn_q[i] <= '0;
            end
            rd_addr_q <= 7'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 7'd0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            s_q       <= s_d;
            a_q       <= a_d;
            sn_q      <= sn_d;
            r_q       <= r_d;
            q_sa_q    <= q_sa_d;
            qn_q      <= qn_d;
            rd_addr_q <= rd_addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign q_rd_addr = rd_addr_q;
    assign q_wr_en   = wr_en_q;
    assign q_wr_addr = wr_addr_q;
    assign q_wr_data = wr_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_q_update_unit.sv
// Directed, table-driven bench for q_update_unit with a behavioural Q-table
// (registered read) and hand-written multi-cycle sequences.
module tb_q_update_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  current_state;
    logic [3:0]  at;
    logic [5:0]  next_state;
    logic [15:0] reward;
    logic [6:0]  q_rd_addr;
    logic [15:0] q_rd_data;
    logic        q_wr_en;
    logic [6:0]  q_wr_addr;
    logic [15:0] q_wr_data;
    logic        busy;
    logic        done;
    logic        err;

    logic [15:0] mem [0:127];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          s;
        int          a;
        int          sn;
        logic [15:0] r;
        logic [15:0] qsa;
        logic [15:0] qn0;
        logic [15:0] qn1;
        logic [15:0] qn2;
        logic [15:0] qn3;
        int          exp_addr;
        logic [15:0] exp_data;
        int          exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [12];

    q_update_unit dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .current_state (current_state),
        .at            (at),
        .next_state    (next_state),
        .reward        (reward),
        .q_rd_addr     (q_rd_addr),
        .q_rd_data     (q_rd_data),
        .q_wr_en       (q_wr_en),
        .q_wr_addr     (q_wr_addr),
        .q_wr_data     (q_wr_data),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    // External Q-table: read data appears one cycle after the address.
    always @(posedge clk) q_rd_data <= mem[q_rd_addr];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic load_vec(input vec_t v);
        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
        if (v.s >= 1 && v.s <= 25 && v.a < 4) mem[(v.s - 1) * 4 + v.a] = v.qsa;
        if (v.sn >= 1 && v.sn <= 25) begin
            mem[(v.sn - 1) * 4 + 0] = v.qn0;
            mem[(v.sn - 1) * 4 + 1] = v.qn1;
            mem[(v.sn - 1) * 4 + 2] = v.qn2;
            mem[(v.sn - 1) * 4 + 3] = v.qn3;
        end
    endtask

    // Issue one request, scramble inputs after the sampling edge, and watch
    // 20 cycles recording the first done and every write strobe.
    task automatic run_op(input int s, input int a, input int sn, input logic [15:0] r,
                          output int lat, output int ndone, output int nwr,
                          output int addr, output int data, output int errv);
        @(negedge clk);
        current_state = 6'(s);
        at            = 4'(a);
        next_state    = 6'(sn);
        reward        = r;
        start         = 1'b1;
        @(posedge clk);
        #1;
        start         = 1'b0;
        current_state = 6'($urandom_range(0, 63));
        at            = 4'($urandom_range(0, 15));
        next_state    = 6'($urandom_range(0, 63));
        reward        = 16'($urandom);
        lat = -1; ndone = 0; nwr = 0; addr = -1; data = -1; errv = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (q_wr_en) nwr++;
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat  = c;
                    addr = int'(q_wr_addr);
                    data = int'(q_wr_data);
                    errv = int'(err);
                end
            end
        end
    endtask

    initial begin
        int lat, ndone, nwr, addr, data, errv;
        int d1, d2, cnt_done, cnt_wr;

        //           s   a  sn  r         qsa       qn0       qn1       qn2       qn3      addr data      err lat
        vecs[0]  = '{1,  0, 2,  16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0,  16'h0040, 0, 8};
        vecs[1]  = '{2,  3, 7,  16'h0100, 16'h0000, 16'h0100, 16'hFE00, 16'h0300, 16'h0080, 7,  16'h00EC, 0, 8};
        vecs[2]  = '{24, 0, 25, 16'h0100, 16'h0000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 92, 16'h0040, 0, 8};
        vecs[3]  = '{3,  1, 4,  16'h7FFF, 16'h7F00, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 9,  16'h7FFF, 0, 8};
        vecs[4]  = '{5,  2, 6,  16'h8000, 16'h8100, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 18, 16'h8000, 0, 8};
        vecs[5]  = '{10, 1, 11, 16'h0000, 16'h0200, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 37, 16'h0146, 0, 8};
        vecs[6]  = '{13, 2, 12, 16'hFF80, 16'h0100, 16'h0400, 16'h0400, 16'h8000, 16'h0010, 50, 16'h0186, 0, 8};
        vecs[7]  = '{20, 3, 19, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFE, 16'hFFFD, 16'h0200, 79, 16'h0073, 0, 8};
        vecs[8]  = '{0,  0, 2,  16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0,  16'h0000, 1, 1};
        vecs[9]  = '{1,  4, 2,  16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0,  16'h0000, 1, 1};
        vecs[10] = '{1,  0, 26, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0,  16'h0000, 1, 1};
        vecs[11] = '{26, 1, 3,  16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0,  16'h0000, 1, 1};

        rst = 1'b1; start = 1'b0;
        current_state = 6'd0; at = 4'd0; next_state = 6'd0; reward = 16'h0000;
        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy",    int'(busy),      0);
        check("reset_done",    int'(done),      0);
        check("reset_err",     int'(err),       0);
        check("reset_wr_en",   int'(q_wr_en),   0);
        check("reset_wr_addr", int'(q_wr_addr), 0);
        check("reset_wr_data", int'(q_wr_data), 0);
        check("reset_rd_addr", int'(q_rd_addr), 0);
        rst = 1'b0;

        // Table-driven vectors.
        for (int v = 0; v < 12; v++) begin
            load_vec(vecs[v]);
            run_op(vecs[v].s, vecs[v].a, vecs[v].sn, vecs[v].r, lat, ndone, nwr, addr, data, errv);
            $display("vec %0d: s=%0d a=%0d s'=%0d r=0x%04h -> lat=%0d done=%0d wr=%0d addr=%0d data=0x%04h err=%0d",
                     v, vecs[v].s, vecs[v].a, vecs[v].sn, vecs[v].r, lat, ndone, nwr, addr, data & 16'hFFFF, errv);
            check($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat);
            check($sformatf("vec%0d_done_count", v), ndone, 1);
            check($sformatf("vec%0d_err", v), errv, vecs[v].exp_err);
            check($sformatf("vec%0d_write_count", v), nwr, (vecs[v].exp_err != 0) ? 0 : 1);
            if (vecs[v].exp_err == 0) begin
                check($sformatf("vec%0d_wr_addr", v), addr, vecs[v].exp_addr);
                check($sformatf("vec%0d_wr_data", v), data, int'(vecs[v].exp_data));
            end
        end

        // Reset in the 4th FETCH cycle abandons the update without a write.
        load_vec(vecs[0]);
        @(negedge clk);
        current_state = 6'd1; at = 4'd0; next_state = 6'd2; reward = 16'h0100; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_busy_before", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy_after", int'(busy), 0);
        check("abort_rd_addr", int'(q_rd_addr), 0);
        cnt_done = 0; cnt_wr = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) cnt_done++;
            if (q_wr_en) cnt_wr++;
        end
        $display("abort: dones=%0d writes=%0d after reset", cnt_done, cnt_wr);
        check("abort_no_done", cnt_done, 0);
        check("abort_no_write", cnt_wr, 0);
        run_op(1, 0, 2, 16'h0100, lat, ndone, nwr, addr, data, errv);
        $display("post-abort op: lat=%0d data=0x%04h", lat, data & 16'hFFFF);
        check("post_abort_data", data, 16'h0040);

        // start pulsed while busy is ignored: exactly one done, original result.
        load_vec(vecs[1]);
        @(negedge clk);
        current_state = 6'd2; at = 4'd3; next_state = 6'd7; reward = 16'h0100; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cnt_done = 0; d1 = -1; data = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 3) begin
                current_state = 6'd1; at = 4'd0; next_state = 6'd2; reward = 16'h0000; start = 1'b1;
            end
            if (c == 4) start = 1'b0;
            if (done) begin
                cnt_done++;
                if (d1 < 0) begin d1 = c; data = int'(q_wr_data); end
            end
        end
        $display("busy-start: dones=%0d first_done=%0d data=0x%04h", cnt_done, d1, data & 16'hFFFF);
        check("busy_done_count", cnt_done, 1);
        check("busy_done_cycle", d1, 8);
        check("busy_wr_data", data, 16'h00EC);

        // start held high: next request accepted in the cycle after done.
        load_vec(vecs[0]);
        @(negedge clk);
        current_state = 6'd1; at = 4'd0; next_state = 6'd2; reward = 16'h0100; start = 1'b1;
        @(posedge clk);
        d1 = -1; d2 = -1; cnt_done = 0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (done) begin
                cnt_done++;
                if (d1 < 0) d1 = c;
                else if (d2 < 0) begin d2 = c; start = 1'b0; end
            end
        end
        start = 1'b0;
        $display("back-to-back: done cycles %0d and %0d, total %0d", d1, d2, cnt_done);
        check("b2b_first_done", d1, 8);
        check("b2b_second_done", d2, 17);
        check("b2b_done_count", cnt_done, 2);

        // rst wins over start in the same cycle.
        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        current_state = 6'd1; at = 4'd0; next_state = 6'd2; reward = 16'h0100;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_priority_busy", int'(busy), 0);
        cnt_done = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done) cnt_done++;
        end
        $display("rst+start: busy=%0d dones=%0d", busy, cnt_done);
        check("rst_priority_no_done", cnt_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
